spin_speed_ramp: RTL and testbench

- Upstream stage of the reel clock divider.
- Generates the 20-bit `speed` word (step-clock frequency in Hz) and the divider's reset strobe for one slot reel.
- On a spin request, ramps speed up to a cruise value, holds it, then decelerates to a floor and reports completion. This gives the reel a realistic spin-up/coast/slow-down profile.
- The divider computes BASESPEED/speed, so `speed` is never 0.

---
 rtl/slot_pkg.sv | 42 ++++
 rtl/ramp_tick_gen.sv | 33 +++
 rtl/spin_speed_ramp.sv | 120 ++++++++++++
 tb/tb_spin_speed_ramp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and saturating speed arithmetic for the slot reel drive chain.
package slot_pkg;

    localparam int unsigned SPEED_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        DONE
    } ramp_state_t;

    // One extra bit of headroom so the sum can never wrap before clamping.
    function automatic logic [SPEED_W-1:0] sat_add(
        input logic [SPEED_W-1:0] a,
        input logic [SPEED_W-1:0] step,
        input logic [SPEED_W-1:0] hi
    );
        logic [SPEED_W:0] sum;
        sum = {1'b0, a} + {1'b0, step};
        if (sum > {1'b0, hi}) begin
            return hi;
        end
        return sum[SPEED_W-1:0];
    endfunction

    // Signed difference so a step larger than the current speed clamps instead of wrapping.
    function automatic logic [SPEED_W-1:0] sat_sub(
        input logic [SPEED_W-1:0] a,
        input logic [SPEED_W-1:0] step,
        input logic [SPEED_W-1:0] lo
    );
        logic signed [SPEED_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, step});
        if (diff < $signed({1'b0, lo})) begin
            return lo;
        end
        return diff[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running period counter: one-cycle tick every RAMP_PERIOD clocks, restartable.
module ramp_tick_gen #(
    parameter int unsigned RAMP_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(RAMP_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spin_speed_ramp.sv
// Spin profile generator: ramps the reel step frequency up, holds cruise, ramps down,
// and strobes the downstream clock divider reset when a spin starts.
module spin_speed_ramp
    import slot_pkg::*;
#(
    parameter int unsigned         BASESPEED    = 50000000,
    parameter int unsigned         RAMP_PERIOD  = 5000000,
    parameter logic [SPEED_W-1:0]  MIN_SPEED    = 20'd2,
    parameter logic [SPEED_W-1:0]  MAX_SPEED    = 20'd40,
    parameter logic [SPEED_W-1:0]  ACC_STEP     = 20'd3,
    parameter logic [SPEED_W-1:0]  DEC_STEP     = 20'd2,
    parameter logic [15:0]         CRUISE_TICKS = 16'd20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_req,
    output logic [SPEED_W-1:0] speed,
    output logic               div_rst,
    output logic               busy,
    output logic               done
);

    if (RAMP_PERIOD < 2 || BASESPEED < RAMP_PERIOD || MIN_SPEED == '0
        || MAX_SPEED <= MIN_SPEED) begin : g_bad_params
        $error("spin_speed_ramp: illegal parameter combination");
    end

    ramp_state_t        state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [15:0]        cruise_q, cruise_d;
    logic [1:0]         div_cnt_q, div_cnt_d;
    logic               tick;
    logic               restart;

    // Every state change realigns the tick grid to the new phase.
    assign restart = (state_d != state_q);

    ramp_tick_gen #(
        .RAMP_PERIOD(RAMP_PERIOD)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            speed_q   <= MIN_SPEED;
            cruise_q  <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            cruise_q  <= cruise_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        speed_d   = speed_q;
        cruise_d  = cruise_q;
        div_cnt_d = (div_cnt_q != 2'd0) ? div_cnt_q - 2'd1 : 2'd0;
        case (state_q)
            IDLE: begin
                speed_d = MIN_SPEED;
                if (start) begin
                    state_d   = ACCEL;
                    div_cnt_d = 2'd2;
                end
            end
            ACCEL: begin
                if (tick) begin
                    speed_d = sat_add(speed_q, ACC_STEP, MAX_SPEED);
                end
                // An early stop outranks reaching cruise on the same tick.
                if (stop_req) begin
                    state_d = DECEL;
                end else if (tick && speed_d == MAX_SPEED) begin
                    state_d = CRUISE;
                end
            end
            CRUISE: begin
                speed_d = MAX_SPEED;
                if (tick) begin
                    cruise_d = cruise_q + 16'd1;
                end
                if (stop_req || (tick && (cruise_q + 16'd1) == CRUISE_TICKS)) begin
                    state_d  = DECEL;
                    cruise_d = '0;
                end
            end
            DECEL: begin
                if (tick) begin
                    speed_d = sat_sub(speed_q, DEC_STEP, MIN_SPEED);
                    if (speed_d == MIN_SPEED) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        speed   = speed_q;
        div_rst = (div_cnt_q != 2'd0);
        busy    = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);
        done    = (state_q == DONE);
    end

endmodule

// File: tb/tb_spin_speed_ramp.sv
// Scoreboard bench for spin_speed_ramp: a phase-level profile model predicts timed events.
module tb_spin_speed_ramp;

    localparam int P    = 4;
    localparam int MINS = 2;
    localparam int MAXS = 10;
    localparam int ACC  = 3;
    localparam int DEC  = 4;
    localparam int CT   = 2;

    localparam int EV_DIV   = 0;
    localparam int EV_SPEED = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop_req = 1'b0;
    logic [19:0] speed;
    logic        div_rst;
    logic        busy;
    logic        done;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    ev_t         exp_q[$];
    logic [19:0] prev_speed;
    logic        prev_div;

    spin_speed_ramp #(
        .BASESPEED   (50000000),
        .RAMP_PERIOD (P),
        .MIN_SPEED   (20'(MINS)),
        .MAX_SPEED   (20'(MAXS)),
        .ACC_STEP    (20'(ACC)),
        .DEC_STEP    (20'(DEC)),
        .CRUISE_TICKS(16'(CT))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop_req(stop_req),
        .speed   (speed),
        .div_rst (div_rst),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, none expected",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                n_errors++;
                $display("FAIL event: got kind %0d value %0d at cycle %0d, expected kind %0d value %0d at cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Profile model. k is the edge that accepts start, s the edge that samples stop_req
    // (ignored unless it falls inside ACCEL/CRUISE). Times are sample indices after edges.
    task automatic plan_spin(input int k, input int s, output int d);
        int t, e, spd, nxt, ph;
        push(EV_DIV, k, 1);
        push(EV_DIV, k + 2, 0);
        spd = MINS;
        t   = k;
        ph  = 0;
        d   = -1;
        while (d < 0) begin
            if (ph == 0) begin
                e = t + P;
                if (s > t && s < e) begin
                    t  = s;
                    ph = 2;
                end else begin
                    nxt = (spd + ACC > MAXS) ? MAXS : spd + ACC;
                    if (nxt != spd) push(EV_SPEED, e, nxt);
                    spd = nxt;
                    t   = e;
                    if (s == e) ph = 2;
                    else if (spd == MAXS) ph = 1;
                end
            end else if (ph == 1) begin
                e  = t + CT * P;
                t  = (s > t && s <= e) ? s : e;
                ph = 2;
            end else begin
                e   = t + P;
                nxt = (spd - DEC < MINS) ? MINS : spd - DEC;
                if (nxt != spd) push(EV_SPEED, e, nxt);
                spd = nxt;
                t   = e;
                if (spd == MINS) begin
                    push(EV_DONE, e, 1);
                    d = e;
                end
            end
        end
    endtask

    // Called at a negedge; drives one spin to completion plus the DONE cycle.
    task automatic run_spin(input bit has_stop, input int s_off, input bit has_x);
        int k, d, s, x;
        k = cyc + 1;
        s = has_stop ? k + s_off : -1;
        plan_spin(k, s, d);
        x = has_x ? k + 1 + int'($urandom_range(0, d - k)) : -1;
        while (cyc + 1 <= d + 1) begin
            start    = (cyc + 1 == k) || (cyc + 1 == x);
            stop_req = (cyc + 1 == s);
            @(negedge clk);
        end
        start    = 1'b0;
        stop_req = 1'b0;
    endtask

    // Monitor: every output change or done pulse consumes the next expected event.
    initial begin
        prev_speed = 20'(MINS);
        prev_div   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && mon_en) begin
                if (div_rst !== prev_div) expect_ev(EV_DIV, int'(div_rst));
                if (speed !== prev_speed) begin
                    expect_ev(EV_SPEED, int'(speed));
                    check("speed_in_range", 32'(speed >= 20'(MINS) && speed <= 20'(MAXS)), 1);
                end
                if (done) begin
                    expect_ev(EV_DONE, 1);
                    check("busy_low_at_done", 32'(busy), 0);
                end
            end
            prev_speed = speed;
            prev_div   = div_rst;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        #2 rst = 1'b0;
        #1;
        check("reset_speed", 32'(speed), MINS);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_div_rst", 32'(div_rst), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // stop_req alone in IDLE must not wake the ramp
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        @(negedge clk);
        check("idle_stop_busy", 32'(busy), 0);
        check("idle_stop_speed", 32'(speed), MINS);

        run_spin(1'b0, 0, 1'b0);   // full profile
        run_spin(1'b1, 5, 1'b0);   // stop at speed 5
        run_spin(1'b1, 13, 1'b0);  // stop on first CRUISE cycle
        run_spin(1'b1, 12, 1'b0);  // stop coincides with the 8->10 tick
        run_spin(1'b1, 0, 1'b0);   // start and stop together in IDLE
        run_spin(1'b0, 0, 1'b1);   // stray start while busy
        run_spin(1'b1, 1, 1'b0);   // stop right after entry

        for (int i = 0; i < 16; i++) begin
            int mode;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: run_spin(1'b0, 0, 1'($urandom_range(0, 1)));
                1: run_spin(1'b1, int'($urandom_range(1, 14)), 1'($urandom_range(0, 1)));
                2: run_spin(1'b1, int'($urandom_range(12, 22)), 1'($urandom_range(0, 1)));
                default: run_spin(1'b1, 0, 1'($urandom_range(0, 1)));
            endcase
        end
        check("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of deceleration
        mon_en = 1'b0;
        k = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 25) @(negedge clk);
        check("pre_reset_speed", 32'(speed), 6);
        check("pre_reset_busy", 32'(busy), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_speed", 32'(speed), MINS);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_div", 32'(div_rst), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_idle", 32'({busy, speed}), MINS);
        end
        mon_en = 1'b1;
        run_spin(1'b0, 0, 1'b0);
        check("final_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
